// File: rtl/e_mdu_if.sv
// Execute-stage MDU bus: control fields and operands in, busy flag and HI/LO views out.
interface e_mdu_if;
    logic        E_MDU_start;
    logic [3:0]  E_MDUop;
    logic        E_MDUout_sel;
    logic [31:0] E_RD1;
    logic [31:0] E_RD2;
    logic        E_MDU_busy;
    logic [31:0] E_MDU_out;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    modport master (
        output E_MDU_start, E_MDUop, E_MDUout_sel, E_RD1, E_RD2,
        input  E_MDU_busy, E_MDU_out, E_HI, E_LO
    );

    modport slave (
        input  E_MDU_start, E_MDUop, E_MDUout_sel, E_RD1, E_RD2,
        output E_MDU_busy, E_MDU_out, E_HI, E_LO
    );
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO, with a busy window modelling latency.
// Optional MADD/MADDU accumulate ops are enabled by defining MDU_MADD_EN.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  bus
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OpMadd  = 4'd7;
    localparam logic [3:0] OpMaddu = 4'd8;
`endif

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

    logic [31:0] a, b;
    logic [63:0] prod_s, prod_u;
    logic        div_signed;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign a = bus.E_RD1;
    assign b = bus.E_RD2;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes; 0x80000000 negates to itself, which is the right
    // unsigned magnitude, so the overflow case falls out as LO=0x80000000, HI=0.
    assign div_signed = (bus.E_MDUop == OpDiv);
    assign a_mag = (div_signed && a[31]) ? (32'd0 - a) : a;
    assign b_mag = (div_signed && b[31]) ? (32'd0 - b) : b;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    assign quot  = (div_signed && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
    assign rem   = (div_signed && a[31]) ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        case (state_q)
            StIdle: begin
                if (bus.E_MDU_start) begin
                    case (bus.E_MDUop)
                        OpMult: begin
                            {hi_tmp_d, lo_tmp_d} = prod_s;
                            cnt_d   = CntW'(MULT_CYCLES);
                            state_d = StBusy;
                        end
                        OpMultu: begin
                            {hi_tmp_d, lo_tmp_d} = prod_u;
                            cnt_d   = CntW'(MULT_CYCLES);
                            state_d = StBusy;
                        end
                        OpDiv, OpDivu: begin
                            // Divide by zero stages the current HI/LO so the commit is a no-op.
                            if (b != 32'd0) begin
                                hi_tmp_d = rem;
                                lo_tmp_d = quot;
                            end else begin
                                hi_tmp_d = hi_q;
                                lo_tmp_d = lo_q;
                            end
                            cnt_d   = CntW'(DIV_CYCLES);
                            state_d = StBusy;
                        end
                        OpMthi: hi_d = a;
                        OpMtlo: lo_d = a;
`ifdef MDU_MADD_EN
                        OpMadd: begin
                            {hi_tmp_d, lo_tmp_d} = {hi_q, lo_q} + prod_s;
                            cnt_d   = CntW'(MULT_CYCLES);
                            state_d = StBusy;
                        end
                        OpMaddu: begin
                            {hi_tmp_d, lo_tmp_d} = {hi_q, lo_q} + prod_u;
                            cnt_d   = CntW'(MULT_CYCLES);
                            state_d = StBusy;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    hi_d    = hi_tmp_q;
                    lo_d    = lo_tmp_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end

    assign bus.E_MDU_busy = (state_q == StBusy);
    assign bus.E_MDU_out  = bus.E_MDUout_sel ? hi_q : lo_q;
    assign bus.E_HI       = hi_q;
    assign bus.E_LO       = lo_q;
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: per-cycle comparison against an arithmetic model of HI/LO and
// the busy window, plus literal expectations for the worked examples.
module tb_e_mdu;
    localparam int MultN = 5;
    localparam int DivN  = 10;
`ifdef MDU_MADD_EN
    localparam bit MaddEn = 1'b1;
`else
    localparam bit MaddEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    e_mdu_if bus ();

    e_mdu #(
        .MULT_CYCLES (MultN),
        .DIV_CYCLES  (DivN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one MDU op given operands and the HI/LO it starts from.
    function automatic logic [63:0] model_op(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
        longint sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sp = sa * sb;
        up = ua * ub;
        case (op)
            4'd1: return sp;
            4'd2: return up;
            4'd3: begin
                if (b == 32'd0) return {hi, lo};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            4'd4: begin
                if (b == 32'd0) return {hi, lo};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            4'd7: return {hi, lo} + 64'(sp);
            4'd8: return {hi, lo} + up;
            default: return {hi, lo};
        endcase
    endfunction

    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    int m_rem = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_hi <= '0; m_lo <= '0; m_phi <= '0; m_plo <= '0; m_rem <= 0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_hi <= m_phi;
                m_lo <= m_plo;
            end
        end else if (bus.E_MDU_start) begin
            if (bus.E_MDUop inside {4'd1, 4'd2, 4'd3, 4'd4} ||
                (MaddEn && bus.E_MDUop inside {4'd7, 4'd8})) begin
                {m_phi, m_plo} <= model_op(bus.E_MDUop, bus.E_RD1, bus.E_RD2, m_hi, m_lo);
                m_rem <= (bus.E_MDUop inside {4'd3, 4'd4}) ? DivN : MultN;
            end else if (bus.E_MDUop == 4'd5) begin
                m_hi <= bus.E_RD1;
            end else if (bus.E_MDUop == 4'd6) begin
                m_lo <= bus.E_RD1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 32'(bus.E_MDU_busy), 32'(m_rem > 0));
            check("cyc_hi", bus.E_HI, m_hi);
            check("cyc_lo", bus.E_LO, m_lo);
            check("cyc_out", bus.E_MDU_out, bus.E_MDUout_sel ? m_hi : m_lo);
        end
    end

    // Issues a one-cycle start and returns how many cycles busy stayed high afterwards.
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
        @(posedge clk); #1;
        bus.E_MDU_start = 1'b1;
        bus.E_MDUop     = op;
        bus.E_RD1       = a;
        bus.E_RD2       = b;
        @(posedge clk); #1;
        bus.E_MDU_start = 1'b0;
        bus.E_MDUop     = 4'd0;
        cyc = 0;
        while (bus.E_MDU_busy && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int cyc;
        bus.E_MDU_start  = 1'b0;
        bus.E_MDUop      = 4'd0;
        bus.E_MDUout_sel = 1'b0;
        bus.E_RD1        = '0;
        bus.E_RD2        = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_hi", bus.E_HI, 32'h0);
        check("rst_lo", bus.E_LO, 32'h0);
        check("rst_busy", 32'(bus.E_MDU_busy), 32'd0);
        check("rst_out", bus.E_MDU_out, 32'h0);

        run(4'd1, 32'hFFFF_FFFE, 32'd3, cyc);
        check("mult_cycles", cyc, MultN);
        check("mult_hi", bus.E_HI, 32'hFFFF_FFFF);
        check("mult_lo", bus.E_LO, 32'hFFFF_FFFA);

        bus.E_MDUout_sel = 1'b1;
        run(4'd2, 32'hFFFF_FFFF, 32'd2, cyc);
        check("multu_hi", bus.E_HI, 32'h1);
        check("multu_lo", bus.E_LO, 32'hFFFF_FFFE);
        check("multu_out_hi", bus.E_MDU_out, 32'h1);
        bus.E_MDUout_sel = 1'b0;
        #1 check("out_lo_sel", bus.E_MDU_out, 32'hFFFF_FFFE);

        run(4'd3, -32'sd7, 32'd2, cyc);
        check("div_cycles", cyc, DivN);
        check("div_lo", bus.E_LO, 32'hFFFF_FFFD);
        check("div_hi", bus.E_HI, 32'hFFFF_FFFF);

        run(4'd4, 32'd99, 32'd0, cyc);
        check("divu0_cycles", cyc, DivN);
        check("divu0_hi", bus.E_HI, 32'hFFFF_FFFF);
        check("divu0_lo", bus.E_LO, 32'hFFFF_FFFD);

        run(4'd3, 32'd7, -32'sd2, cyc);
        check("div_negb_lo", bus.E_LO, 32'hFFFF_FFFD);
        check("div_negb_hi", bus.E_HI, 32'h1);

        run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("div_ovf_lo", bus.E_LO, 32'h8000_0000);
        check("div_ovf_hi", bus.E_HI, 32'h0);

        run(4'd4, 32'hFFFF_FFFF, 32'd16, cyc);
        check("divu_lo", bus.E_LO, 32'h0FFF_FFFF);
        check("divu_hi", bus.E_HI, 32'hF);

        run(4'd5, 32'h1234, 32'd0, cyc);
        check("mthi_busy", cyc, 0);
        run(4'd6, 32'h5678, 32'd0, cyc);
        check("mtlo_busy", cyc, 0);
        check("mthi_hi", bus.E_HI, 32'h1234);
        check("mtlo_lo", bus.E_LO, 32'h5678);

        run(4'd9, 32'hDEAD, 32'hBEEF, cyc);
        check("op9_busy", cyc, 0);
        run(4'd0, 32'hDEAD, 32'hBEEF, cyc);
        check("none_hi", bus.E_HI, 32'h1234);
        check("none_lo", bus.E_LO, 32'h5678);

        // Reset lands on the third edge after the start edge.
        @(posedge clk); #1;
        bus.E_MDU_start = 1'b1;
        bus.E_MDUop     = 4'd1;
        bus.E_RD1       = 32'd6;
        bus.E_RD2       = 32'd7;
        @(posedge clk); #1;
        bus.E_MDU_start = 1'b0;
        bus.E_MDUop     = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 32'(bus.E_MDU_busy), 32'd0);
        check("abort_hi", bus.E_HI, 32'h0);
        check("abort_lo", bus.E_LO, 32'h0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_nocommit", bus.E_LO, 32'h0);

        run(4'd5, 32'h0, 32'd0, cyc);
        run(4'd6, 32'hFFFF_FFFF, 32'd0, cyc);
        run(4'd8, 32'd1, 32'd1, cyc);
        if (MaddEn) begin
            check("maddu_cycles", cyc, MultN);
            check("maddu_hi", bus.E_HI, 32'h1);
            check("maddu_lo", bus.E_LO, 32'h0);
        end else begin
            check("maddu_off_cycles", cyc, 0);
            check("maddu_off_hi", bus.E_HI, 32'h0);
            check("maddu_off_lo", bus.E_LO, 32'hFFFF_FFFF);
        end
        run(4'd7, 32'hFFFF_FFFF, 32'd1, cyc);
        if (MaddEn) begin
            check("madd_hi", bus.E_HI, 32'h0);
            check("madd_lo", bus.E_LO, 32'hFFFF_FFFF);
        end else begin
            check("madd_off_busy", cyc, 0);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
